rll_key_pipe: RTL and testbench

RLL_KEY_PIPE -- requirements
Module: rll_key_pipe

---
 rtl/rll_key_pipe_if.sv | 27 ++
 rtl/rll_key_pipe.sv | 129 ++++++++++++
 tb/tb_rll_key_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rll_key_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : rll_key_pipe_if
// Purpose  : Input/output valid-ready stream bundle for the key-locked pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface rll_key_pipe_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/rll_key_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rll_key_pipe
// Purpose  : Serially loaded key locks a STAGES-deep XOR/rotate datapath.
// Revision : 1.0 - initial release
// ============================================================================
module rll_key_pipe #(
    parameter int DATA_W = 8,
    parameter int STAGES = 4,
    parameter int KEY_W  = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       key_shift_en,
    input  wire logic                       key_bit_in,
    input  wire logic                       key_commit,
    rll_key_pipe_if.slave                   bus,
    output logic                            key_loaded,
    output logic [$clog2(KEY_W+1)-1:0]      key_count,
    output logic                            key_err
);
    localparam int                CNT_W      = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0]  C_KEY_FULL = CNT_W'(KEY_W);

    generate
        if (KEY_W != STAGES * DATA_W) begin : g_key_w_check
            $error("rll_key_pipe: KEY_W must equal STAGES*DATA_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_NOKEY   = 2'd0,
        S_LOADING = 2'd1,
        S_ARMED   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [KEY_W-1:0]  r_sr;
    logic [KEY_W-1:0]  r_key;
    logic [CNT_W-1:0]  r_key_count;
    logic              r_key_loaded;
    logic              r_key_err;
    logic              w_commit_ok;
    logic              w_commit_bad;

    // Commit is judged on the pre-shift count; a same-cycle shift lands after it.
    assign w_commit_ok  = key_commit && (r_key_count == C_KEY_FULL);
    assign w_commit_bad = key_commit && !w_commit_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_NOKEY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_NOKEY:   if (key_shift_en) w_state_nxt = S_LOADING;
            S_LOADING: if (w_commit_ok)  w_state_nxt = key_shift_en ? S_LOADING : S_ARMED;
            S_ARMED:   if (key_shift_en) w_state_nxt = S_LOADING;
            default:   w_state_nxt = S_NOKEY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr         <= '0;
            r_key        <= '0;
            r_key_count  <= '0;
            r_key_loaded <= 1'b0;
            r_key_err    <= 1'b0;
        end else begin
            r_key_err <= w_commit_bad;
            if (w_commit_ok) begin
                r_key        <= r_sr;
                r_key_loaded <= 1'b1;
            end
            if (key_shift_en) r_sr <= {key_bit_in, r_sr[KEY_W-1:1]};
            if (w_commit_ok)
                r_key_count <= key_shift_en ? CNT_W'(1) : '0;
            else if (key_shift_en && (r_key_count != C_KEY_FULL))
                r_key_count <= r_key_count + 1'b1;
        end
    end

    assign key_loaded = r_key_loaded;
    assign key_count  = r_key_count;
    assign key_err    = r_key_err;

    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
        return (v << 1) | (v >> (DATA_W - 1));
    endfunction

    logic [STAGES-1:0] r_valid;
    logic [DATA_W-1:0] r_data    [STAGES];
    logic [DATA_W-1:0] w_stage_d [STAGES];
    logic [DATA_W-1:0] w_stage_q [STAGES];
    logic              w_adv;

    // Single global advance: the whole pipe freezes when the tail is blocked.
    assign w_adv        = !r_valid[STAGES-1] || bus.out_ready;
    assign bus.in_ready = w_adv && r_key_loaded;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            if (s == 0) begin : g_first
                assign w_stage_d[s] = bus.in_data;
            end else begin : g_next
                assign w_stage_d[s] = r_data[s-1];
            end
            assign w_stage_q[s] = rotl1(w_stage_d[s] ^ r_key[s*DATA_W +: DATA_W]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int s = 0; s < STAGES; s++) r_data[s] <= '0;
        end else if (w_adv) begin
            r_valid <= (r_valid << 1) | STAGES'(bus.in_valid && r_key_loaded);
            for (int s = 0; s < STAGES; s++) r_data[s] <= w_stage_q[s];
        end
    end

    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.out_data  = r_data[STAGES-1];
endmodule
`default_nettype wire

// File: tb/tb_rll_key_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rll_key_pipe
// Purpose  : Randomized self-checking bench for rll_key_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rll_key_pipe;
    localparam int DATA_W = 8;
    localparam int STAGES = 4;
    localparam int KEY_W  = 32;
    localparam int CNT_W  = $clog2(KEY_W + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_shift_en = 1'b0;
    logic             key_bit_in = 1'b0;
    logic             key_commit = 1'b0;
    logic             key_loaded;
    logic             key_err;
    logic [CNT_W-1:0] key_count;

    rll_key_pipe_if #(.DATA_W(DATA_W)) bus ();

    rll_key_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .KEY_W(KEY_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_shift_en (key_shift_en),
        .key_bit_in   (key_bit_in),
        .key_commit   (key_commit),
        .bus          (bus),
        .key_loaded   (key_loaded),
        .key_count    (key_count),
        .key_err      (key_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference state: key register contents, bit count, committed key.
    logic [KEY_W-1:0]  m_sr = '0;
    logic [KEY_W-1:0]  m_key = '0;
    int                m_cnt = 0;
    bit                m_loaded = 1'b0;
    logic [DATA_W-1:0] exp_q[$];
    bit                mon_en = 1'b0;

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d, input logic [KEY_W-1:0] k);
        logic [DATA_W-1:0] v;
        v = d;
        for (int s = 0; s < STAGES; s++) begin
            v = v ^ k[s*DATA_W +: DATA_W];
            v = {v[DATA_W-2:0], v[DATA_W-1]};
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
                    else chk("out_data", bus.out_data, exp_q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) exp_q.push_back(xform(bus.in_data, m_key));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_sr = '0; m_key = '0; m_cnt = 0; m_loaded = 1'b0;
    endtask

    task automatic key_op(input bit sh, input bit b, input bit cm);
        bit exp_err;
        exp_err = 1'b0;
        key_shift_en = sh; key_bit_in = b; key_commit = cm;
        step();
        key_shift_en = 1'b0; key_bit_in = 1'b0; key_commit = 1'b0;
        if (cm) begin
            if (m_cnt == KEY_W) begin
                m_key = m_sr; m_loaded = 1'b1; m_cnt = 0;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (sh) begin
            m_sr = {b, m_sr[KEY_W-1:1]};
            if (m_cnt < KEY_W) m_cnt++;
        end
        chk("key_count", key_count, m_cnt);
        chk("key_loaded", key_loaded, m_loaded);
        chk("key_err", key_err, exp_err);
    endtask

    task automatic load_key(input logic [KEY_W-1:0] k);
        for (int i = 0; i < KEY_W; i++) key_op(1'b1, k[i], 1'b0);
        key_op(1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle"}, bus.out_valid, 0);
    endtask

    task automatic send_burst(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = DATA_W'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic rand_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.in_valid  = ($urandom_range(3, 0) != 0);
            bus.in_data   = DATA_W'($urandom);
            bus.out_ready = ($urandom_range(2, 0) != 0);
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        logic [DATA_W-1:0] w0;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        step(); step();
        mon_en = 1'b1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_key_loaded", key_loaded, 0);
        chk("rst_key_count", key_count, 0);
        chk("rst_key_err", key_err, 0);
        rst_n = 1'b1;
        model_reset();

        // No key: words must be refused
        bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("nokey_in_ready", bus.in_ready, 0);
            chk("nokey_out_valid", bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;

        // Key 0x01010101, latency and value of a single word
        load_key(32'h0101_0101);
        bus.in_data = 8'h00; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin step(); lat++; end
        chk("latency", lat, 4);
        chk("out_1e", bus.out_data, 8'h1E);
        drain("k01");

        // All-zero key: single word, then three back-to-back
        load_key('0);
        bus.in_data = 8'hA5; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin step(); n++; end
        chk("zero_a5", bus.out_data, 8'h5A);
        drain("zero1");
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5; step();
        bus.in_data = 8'hFF; step();
        bus.in_data = 8'h00; step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin step(); n++; end
        chk("b2b_0", bus.out_data, 8'h5A);
        step();
        chk("b2b_1_valid", bus.out_valid, 1);
        chk("b2b_1", bus.out_data, 8'hFF);
        step();
        chk("b2b_2_valid", bus.out_valid, 1);
        chk("b2b_2", bus.out_data, 8'h00);
        drain("zero3");

        // Early commit is rejected; the completing shift then commits
        for (int i = 0; i < KEY_W - 1; i++) key_op(1'b1, 1'($urandom), 1'b0);
        key_op(1'b0, 1'b0, 1'b1);
        step();
        chk("err_one_cycle", key_err, 0);
        key_op(1'b1, 1'($urandom), 1'b0);
        key_op(1'b0, 1'b0, 1'b1);
        send_burst(6);
        drain("rekey");

        // Saturating count, then commit and shift in the same cycle
        for (int i = 0; i < KEY_W + 2; i++) key_op(1'b1, 1'($urandom), 1'b0);
        key_op(1'b1, 1'($urandom), 1'b1);
        send_burst(6);
        drain("cmt_shift");

        // Backpressure with the pipe full
        bus.out_ready = 1'b0;
        w0 = DATA_W'($urandom);
        for (int i = 0; i < STAGES; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = (i == 0) ? w0 : DATA_W'($urandom);
            chk("bp_accept", bus.in_ready, 1);
            step();
        end
        bus.in_data = DATA_W'($urandom);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_hold", bus.out_data, xform(w0, m_key));
            step();
        end
        bus.out_ready = 1'b1;
        step();
        drain("bp");

        // Randomized traffic under two random keys
        for (int r = 0; r < 2; r++) begin
            load_key(KEY_W'($urandom));
            rand_traffic(400);
            drain("rand");
        end

        // Reset in the middle of a stream
        bus.out_ready = 1'b1;
        send_burst(6);
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_key_loaded", key_loaded, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_key_count", key_count, 0);
        step();
        chk("post_rst_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        load_key(KEY_W'($urandom));
        rand_traffic(200);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
